// File: rtl/output_align_pkg.sv
// Shared constants for the load-result alignment block: FSM encoding, size codes, bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package output_align_pkg;

    localparam int LINE_W = 128;
    localparam int OUT_W  = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_4B = 2'b10;
    localparam logic [1:0] SZ_8B = 2'b11;

    // Number of valid result bytes for a size code.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_1B:   size_bytes = 4'd1;
            SZ_2B:   size_bytes = 4'd2;
            SZ_4B:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/oa_merge.sv
// Shifts the two-line window down by the byte offset and trims to the access size (optional sign fill, OUTPUT_ALIGN_SEXT_EN).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module oa_merge
    import output_align_pkg::*;
(
    input  logic [2*LINE_W-1:0] lines,
    input  logic [3:0]          off,
    input  logic [1:0]          size,
`ifdef OUTPUT_ALIGN_SEXT_EN
    input  logic                sext,
`endif
    output logic [OUT_W-1:0]    merged
);

    logic [OUT_W-1:0] low;
    logic [3:0]       nbytes;
    logic [7:0]       fill;

    // Byte-granular right shift of the concatenated lines; only the low 64 bits matter.
    always_comb begin
        low    = OUT_W'(lines >> {off, 3'b000});
        nbytes = size_bytes(size);
    end

`ifdef OUTPUT_ALIGN_SEXT_EN
    // Fill pattern for bytes above the size: copies of the sign bit of the top valid byte.
    always_comb begin
        fill = 8'h00;
        case (size)
            SZ_1B:   fill = {8{sext & low[7]}};
            SZ_2B:   fill = {8{sext & low[15]}};
            SZ_4B:   fill = {8{sext & low[31]}};
            default: fill = {8{sext & low[63]}};
        endcase
    end
`else
    // Without sign extension, bytes above the size are always zero.
    always_comb fill = 8'h00;
`endif

    // Keep bytes below the size, substitute the fill pattern above it.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = (4'(i) < nbytes) ? low[8*i +: 8] : fill;
        end
    end

endmodule

// File: rtl/output_align.sv
// Collects line-0/line-1 read responses for one load, merges and aligns them into a 64-bit result (OUTPUT_ALIGN_SEXT_EN adds req_sext).
// Latency: result registered 1 cycle after the last needed response.
// Backpressure: one access in flight; req_ready only in IDLE, result held in OUT until out_ready.
module output_align
    import output_align_pkg::*;
#(
    parameter int PTC_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_off,
    input  logic [1:0]        req_size,
    input  logic              req_needP1,
    input  logic [PTC_W-1:0]  req_id,
`ifdef OUTPUT_ALIGN_SEXT_EN
    input  logic              req_sext,
`endif
    input  logic              resp0_valid,
    input  logic [LINE_W-1:0] resp0_data,
    input  logic              resp1_valid,
    input  logic [LINE_W-1:0] resp1_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [PTC_W-1:0]  out_id,
    output logic              stray_err
);

    logic [1:0]        state;
    logic [3:0]        off_q;
    logic [1:0]        size_q;
    logic              need_q;
    logic [PTC_W-1:0]  id_q;
    logic              got0;
    logic              got1;
    logic [LINE_W-1:0] line0_q;
    logic [LINE_W-1:0] line1_q;
`ifdef OUTPUT_ALIGN_SEXT_EN
    logic              sext_q;
`endif

    logic              take0;
    logic              take1;
    logic              done;
    logic              stray_now;
    logic [LINE_W-1:0] line0_eff;
    logic [LINE_W-1:0] line1_eff;
    logic [OUT_W-1:0]  merged;

    assign req_ready = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);

    // Decide which responses are accepted this cycle, whether the access completes, and whether anything is stray.
    // The merge sees this cycle's response data directly so the result can be registered on the same edge.
    always_comb begin
        take0     = (state == ST_WAIT) && !flush && resp0_valid && !got0;
        take1     = (state == ST_WAIT) && !flush && resp1_valid && !got1;
        done      = (state == ST_WAIT) && !flush && (got0 || take0) && (got1 || take1);
        line0_eff = take0 ? resp0_data : line0_q;
        line1_eff = need_q ? (take1 ? resp1_data : line1_q) : '0;
        stray_now = 1'b0;
        case (state)
            ST_IDLE: stray_now = resp0_valid || resp1_valid;
            ST_WAIT: stray_now = !flush && ((resp0_valid && got0) || (resp1_valid && got1));
            ST_OUT:  stray_now = !flush && (resp0_valid || resp1_valid);
            default: stray_now = 1'b0;
        endcase
    end

    oa_merge u_merge (
        .lines  ({line1_eff, line0_eff}),
        .off    (off_q),
        .size   (size_q),
`ifdef OUTPUT_ALIGN_SEXT_EN
        .sext   (sext_q),
`endif
        .merged (merged)
    );

    // Access FSM with request/response capture; flush abandons WAIT/OUT, reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            off_q     <= '0;
            size_q    <= '0;
            need_q    <= 1'b0;
            id_q      <= '0;
            got0      <= 1'b0;
            got1      <= 1'b0;
            line0_q   <= '0;
            line1_q   <= '0;
            out_data  <= '0;
            out_id    <= '0;
            stray_err <= 1'b0;
`ifdef OUTPUT_ALIGN_SEXT_EN
            sext_q    <= 1'b0;
`endif
        end else begin
            if (stray_now) begin
                stray_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        off_q  <= req_off;
                        size_q <= req_size;
                        need_q <= req_needP1;
                        id_q   <= req_id;
                        got0   <= 1'b0;
                        got1   <= ~req_needP1;
`ifdef OUTPUT_ALIGN_SEXT_EN
                        sext_q <= req_sext;
`endif
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        got0  <= 1'b0;
                        got1  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (take0) begin
                            line0_q <= resp0_data;
                            got0    <= 1'b1;
                        end
                        if (take1) begin
                            line1_q <= resp1_data;
                            got1    <= 1'b1;
                        end
                        if (done) begin
                            out_data <= merged;
                            out_id   <= id_q;
                            state    <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (flush) begin
                        out_data <= '0;
                        out_id   <= '0;
                        state    <= ST_IDLE;
                    end else if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/output_align.md
OUTPUT_ALIGN -- requirements
Module: output_align

Interface
REQ-001 Parameter PTC_W, default 7, width of the request tag carried through with each access.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  a split or unsplit load has been issued to the banks.
REQ-005 req_ready  out  1  block can accept a new request.
REQ-006 req_off  in  4  byte offset of the access within line 0 (address bits [3:0]).
REQ-007 req_size  in  2  access size: 00=1, 01=2, 10=4, 11=8 bytes.
REQ-008 req_needP1  in  1  the access also spans line 1.
REQ-009 req_id  in  PTC_W  tag returned with the merged result.
REQ-010 resp0_valid / resp0_data  in  1 / 128  line-0 read data.
REQ-011 resp1_valid / resp1_data  in  1 / 128  line-1 read data.
REQ-012 flush  in  1  abort the outstanding access.
REQ-013 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-014 out_data / out_id  out  64 / PTC_W  aligned result and its tag.
REQ-015 stray_err  out  1  sticky flag: an unexpected response was received.

Function
REQ-016 The FSM SHALL have 3 states: IDLE, WAIT, OUT; req_ready=1 only in IDLE.
REQ-017 IDLE with req_valid: latch off, size, needP1 and id; clear got0; set got1=~req_needP1; go to WAIT.
REQ-018 WAIT: resp0_valid latches resp0_data and sets got0; resp1_valid latches resp1_data and sets got1.
- Both responses may arrive in the same cycle.
- A response whose got flag is already set is dropped and sets stray_err.
REQ-019 In WAIT, when got0 and got1 become true (including via this cycle's responses), the merged result is registered and the state goes to OUT: out_valid rises 1 cycle after the last response.
REQ-020 Merge rule:
- out_data = low 64 bits of ({line1, line0} >> 8*off).
- Bytes at or above the size are zeroed.
- line1 is treated as zero when needP1=0.
REQ-021 OUT: out_valid=1 and out_data/out_id are held stable until out_ready; on out_valid&out_ready, go to IDLE.
- No back-to-back acceptance in the same cycle: req_ready stays 0 in OUT.
REQ-022 A response arriving in IDLE or OUT is ignored and sets stray_err.
REQ-023 flush in WAIT or OUT SHALL return the FSM to IDLE next cycle, drop out_valid, and discard held data.
- flush has priority over every other event in the same cycle.
- flush in IDLE has no effect.
REQ-024 Only off+size>16 needs line 1, but merging SHALL depend only on req_needP1 as supplied.

Reset
REQ-025 rst SHALL force the state to IDLE, and zero out_valid, out_data, out_id, got0, got1 and stray_err; req_ready=1 in the cycle after reset.
REQ-026 rst asserted mid-WAIT or mid-OUT SHALL abandon the access without emitting a result; rst overrides flush and all responses.

Configuration
REQ-027 Macro OUTPUT_ALIGN_SEXT_EN.
- Defined: adds input req_sext (1 bit), latched with the request; when it is 1, bytes above the size are filled with the sign bit of the top valid byte.
- Undefined: no req_sext port; zero-extension always.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=0, WAIT=1, OUT=2), the size-code constants, and LINE_W=128 / OUT_W=64.
REQ-029 A single sub-module, oa_merge, SHALL be purely combinational: inputs {line1, line0}, off and size; output the 64-bit merged value (plus the sign logic when configured).

Verification
REQ-030 Unsplit access: off=4, size=10, needP1=0; resp0_data bytes[7:4]=DE AD BE EF → out_data=0x00000000_DEADBEEF, 1 cycle after resp0.
REQ-031 Split access: off=14, size=11, needP1=1; line0 bytes[15:14]=11 22, line1 bytes[5:0]=33..88 → out_data bytes[0..7]=11 22 33 44 55 66 77 88; also cover the case where resp1 arrives 3 cycles before resp0.
REQ-032 Responses in the same cycle: both valid in cycle N → out_valid at N+1; out_ready held low for 4 cycles → out_data stable and req_ready=0 throughout.
REQ-033 Duplicate resp0 in WAIT (needP1=1) → first data kept and stray_err=1; a resp1 in IDLE → stray_err=1, no output.
REQ-034 flush in WAIT, then a late resp0 → IDLE with no out_valid, and the late response sets stray_err; rst during OUT → out_valid=0 next cycle.
REQ-035 With OUTPUT_ALIGN_SEXT_EN: off=0, size=00, byte=0x80, req_sext=1 → out_data=0xFFFFFFFF_FFFFFF80; with req_sext=0 → 0x80.
